// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module   : uart_transceiver
//  Purpose  : Full-duplex 8N1 UART, 16x oversampled RX and TX from system clk.
//  Revision : 1.0  initial release
// ============================================================================
module uart_transceiver #(
    parameter int CLOCK_RATE = 42000000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_pin,
    output logic       uart_tx_pin,
    input  logic       uart_tx_start,
    input  logic [7:0] uart_tx_data,
    output logic       uart_tx_busy,
    output logic [7:0] uart_rx_data,
    output logic       uart_rx_valid,
    output logic       uart_rx_error
);

    localparam int DIV_RAW = CLOCK_RATE / (16 * BAUD_RATE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             rx_meta_q, rx_sync_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_div_q, rx_div_d;
    logic [3:0]       rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_error_q, rx_error_d;
    logic             rx_tick;

    assign rx_tick = (rx_div_q == C_DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_div_q   <= '0;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_error_q <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx_pin;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_error_q <= rx_error_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;

        if (rx_state_q == RX_IDLE) begin
            if (!rx_sync_q) begin
                rx_state_d = RX_START;
                rx_div_d   = '0;
                rx_cnt_d   = '0;
            end
        end else begin
            rx_div_d = rx_tick ? '0 : rx_div_q + 1'b1;
            if (rx_tick) begin
                rx_cnt_d = rx_cnt_q + 4'd1;
            end
            case (rx_state_q)
                RX_START: begin
                    // Half a bit in: confirm the start bit is still low.
                    if (rx_tick && rx_cnt_q == 4'd7) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (rx_tick && rx_cnt_q == 4'd15) begin
                        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
                            rx_state_d = RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick && rx_cnt_q == 4'd15) begin
                        rx_state_d = RX_IDLE;
                        if (rx_sync_q) begin
                            rx_data_d  = rx_shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_error_d = 1'b1;
                        end
                    end
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    assign uart_rx_data  = rx_data_q;
    assign uart_rx_valid = rx_valid_q;
    assign uart_rx_error = rx_error_q;

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    tx_state_t        tx_state_q, tx_state_d;
    logic [DIV_W-1:0] tx_div_q, tx_div_d;
    logic [3:0]       tx_cnt_q, tx_cnt_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_shift_q, tx_shift_d;
    logic             tx_pin_q, tx_pin_d;
    logic             tx_busy_q, tx_busy_d;
    logic             tx_tick;
    logic             tx_bit_end;

    assign tx_tick    = (tx_div_q == C_DIV_LAST);
    assign tx_bit_end = tx_tick && (tx_cnt_q == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= '0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_pin_q   <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_pin_q   <= tx_pin_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pin_d   = tx_pin_q;
        tx_busy_d  = tx_busy_q;

        if (tx_state_q == TX_IDLE) begin
            tx_pin_d  = 1'b1;
            tx_busy_d = 1'b0;
            if (uart_tx_start) begin
                tx_shift_d = uart_tx_data;
                tx_state_d = TX_START;
                tx_pin_d   = 1'b0;
                tx_busy_d  = 1'b1;
                tx_div_d   = '0;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end
        end else begin
            tx_div_d = tx_tick ? '0 : tx_div_q + 1'b1;
            if (tx_tick) begin
                tx_cnt_d = tx_cnt_q + 4'd1;
            end
            if (tx_bit_end) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_pin_d   = tx_shift_q[0];
                        tx_state_d = TX_DATA;
                    end
                    TX_DATA: begin
                        // Bit 0 of the shifter is always the bit on the pin.
                        if (tx_bit_q == 3'd7) begin
                            tx_pin_d   = 1'b1;
                            tx_state_d = TX_STOP;
                        end else begin
                            tx_shift_d = {1'b0, tx_shift_q[7:1]};
                            tx_pin_d   = tx_shift_q[1];
                            tx_bit_d   = tx_bit_q + 3'd1;
                        end
                    end
                    TX_STOP: begin
                        tx_pin_d   = 1'b1;
                        tx_busy_d  = 1'b0;
                        tx_state_d = TX_IDLE;
                    end
                    default: tx_state_d = TX_IDLE;
                endcase
            end
        end
    end

    assign uart_tx_pin  = tx_pin_q;
    assign uart_tx_busy = tx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_transceiver
//  Purpose  : Directed self-checking bench for uart_transceiver (default rates).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_transceiver;

    localparam int BIT = 352;   // 16 * (42e6 / (16*115200))

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_pin;
    logic       tx_pin;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    assign rx_pin = loop_en ? tx_pin : rx_drv;

    uart_transceiver dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_pin   (rx_pin),
        .uart_tx_pin   (tx_pin),
        .uart_tx_start (tx_start),
        .uart_tx_data  (tx_data),
        .uart_tx_busy  (tx_busy),
        .uart_rx_data  (rx_data),
        .uart_rx_valid (rx_valid),
        .uart_rx_error (rx_error)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fall_cyc = 0;
    int vcount = 0;
    int ecount = 0;
    int lat = 0;
    int busy_cnt = 0;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcount++;
            rxq.push_back(rx_data);
            lat = cyc - fall_cyc;
        end
        if (rx_error) begin
            ecount++;
            lat = cyc - fall_cyc;
        end
        if (tx_busy) busy_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        vcount = 0;
        ecount = 0;
        lat    = 0;
        rxq.delete();
    endtask

    task automatic drive_bit(input logic b, input int len);
        rx_drv = b;
        repeat (len) @(posedge clk);
        #1;
    endtask

    // A zero stop bit is held only part of a bit so the line is back high
    // before the receiver's next start-bit qualification sample.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #1;
        fall_cyc = cyc;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT);
        if (stop) drive_bit(1'b1, BIT);
        else begin
            drive_bit(1'b0, 264);
            drive_bit(1'b1, BIT - 264);
        end
        drive_bit(1'b1, 2 * BIT);
    endtask

    task automatic wait_busy(input logic lvl, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (tx_busy !== lvl && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk(name, 32'(tx_busy), 32'(lvl));
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_err;
    } rx_vec_t;

    rx_vec_t vecs[6];

    initial begin
        logic [9:0] frame;
        logic [7:0] lb[3];

        vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h73, 1'b1, 8'h73, 1, 0};
        vecs[2] = '{8'h55, 1'b0, 8'h73, 0, 1};
        vecs[3] = '{8'h00, 1'b1, 8'h00, 1, 0};
        vecs[4] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
        vecs[5] = '{8'h3C, 1'b1, 8'h3C, 1, 0};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_pin", 32'(tx_pin), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_error", 32'(rx_error), 32'd0);
        rst = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;

        // Glitch shorter than half a bit
        clear_mon();
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 400);
        chk("glitch_valid", 32'(vcount), 32'd0);
        chk("glitch_error", 32'(ecount), 32'd0);

        // Receive table
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send_frame(vecs[v].data, vecs[v].stop);
            chk($sformatf("rx%0d_valid_cnt", v), 32'(vcount), 32'(vecs[v].exp_valid));
            chk($sformatf("rx%0d_err_cnt", v), 32'(ecount), 32'(vecs[v].exp_err));
            chk($sformatf("rx%0d_data", v), 32'(rx_data), 32'(vecs[v].exp_data));
            chk($sformatf("rx%0d_latency_ok", v), 32'(lat >= 3345 && lat <= 3349), 32'd1);
        end

        // Transmit 0x5A with a mid-frame start that must be ignored
        busy_cnt = 0;
        @(posedge clk);
        #1;
        tx_data  = 8'h5A;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        frame = {1'b1, 8'h5A, 1'b0};
        repeat (176) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("tx_bit%0d", i), 32'(tx_pin), 32'(frame[i]));
            chk($sformatf("tx_busy_bit%0d", i), 32'(tx_busy), 32'd1);
            if (i == 4) begin
                @(posedge clk);
                #1;
                tx_data  = 8'hFF;
                tx_start = 1'b1;
                @(posedge clk);
                #1;
                tx_start = 1'b0;
            end
            if (i < 9) repeat (BIT) @(negedge clk);
        end
        wait_busy(1'b0, "tx_busy_fall_timeout");
        chk("tx_busy_len", 32'(busy_cnt), 32'd3520);
        repeat (50) @(negedge clk);
        chk("tx_idle_busy", 32'(tx_busy), 32'd0);
        chk("tx_idle_pin", 32'(tx_pin), 32'd1);

        // Loopback, back-to-back frames with start held high
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h81;
        loop_en = 1'b1;
        repeat (20) @(posedge clk);
        clear_mon();
        @(negedge clk);
        tx_data  = lb[0];
        tx_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_busy(1'b1, "lb_busy_rise_timeout");
            if (i < 2) tx_data = lb[i + 1];
            else tx_start = 1'b0;
            wait_busy(1'b0, "lb_busy_fall_timeout");
        end
        repeat (2 * BIT) @(negedge clk);
        chk("lb_count", 32'(vcount), 32'd3);
        chk("lb_errors", 32'(ecount), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("lb_byte%0d", i), (rxq.size() > i) ? 32'(rxq[i]) : 32'hDEAD, 32'(lb[i]));
        end
        loop_en = 1'b0;

        // Reset mid-frame aborts transmission
        @(posedge clk);
        #1;
        tx_data  = 8'h00;
        tx_start = 1'b1;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("abort_pre_pin", 32'(tx_pin), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_pin", 32'(tx_pin), 32'd1);
        chk("abort_busy", 32'(tx_busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_stays_idle", 32'(tx_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
